// File: rtl/fmult.sv
// G.726 adaptive predictor FMULT stage: Q14 coefficient times 11-bit float sample,
// returning a 16-bit two's-complement partial product. Purely combinational.
module fmult (
  input  logic        clk,
  input  logic        reset,
  input  logic        scan_in0,
  input  logic        scan_in1,
  input  logic        scan_in2,
  input  logic        scan_in3,
  input  logic        scan_in4,
  input  logic        scan_enable,
  input  logic        test_mode,
  input  logic [15:0] AnBn,
  input  logic [10:0] SRnDQn,
  output logic        scan_out0,
  output logic        scan_out1,
  output logic        scan_out2,
  output logic        scan_out3,
  output logic        scan_out4,
  output logic [15:0] WAnWBn
);

  logic        an_s;
  logic [13:0] an_shift;
  logic [13:0] an_neg;
  logic [12:0] an_mag;
  logic [3:0]  an_exp;
  logic [18:0] an_norm;
  logic [5:0]  an_mant;

  logic        sr_s;
  logic [3:0]  sr_exp;
  logic [5:0]  sr_mant;

  logic        wan_s;
  logic [4:0]  wan_exp;
  logic [11:0] wan_prod;
  logic [7:0]  wan_mant;
  logic [14:0] wan_base;
  logic [14:0] wan_mag;

  // Clock, reset and DFT pins have no functional role; sink them to keep lint quiet.
  logic unused_pins;
  assign unused_pins = ^{clk, reset, scan_in0, scan_in1, scan_in2, scan_in3, scan_in4,
                         scan_enable, test_mode, AnBn[1:0], wan_prod[3:0]};

  assign scan_out0 = 1'b0;
  assign scan_out1 = 1'b0;
  assign scan_out2 = 1'b0;
  assign scan_out3 = 1'b0;
  assign scan_out4 = 1'b0;

  // Coefficient magnitude; the 8192 wrap makes AnBn = 0x8000 collapse to zero.
  assign an_s     = AnBn[15];
  assign an_shift = AnBn[15:2];
  assign an_neg   = 14'd0 - an_shift;
  assign an_mag   = an_s ? an_neg[12:0] : an_shift[12:0];

  always_comb begin
    an_exp = 4'd0;
    for (int i = 0; i < 13; i++) begin
      if (an_mag[i]) an_exp = 4'(i + 1);
    end
  end

  assign an_norm = {an_mag, 6'd0} >> an_exp;
  assign an_mant = (an_mag == 13'd0) ? 6'd32 : an_norm[5:0];

  assign sr_s    = SRnDQn[10];
  assign sr_exp  = SRnDQn[9:6];
  assign sr_mant = SRnDQn[5:0];

  assign wan_s    = sr_s ^ an_s;
  assign wan_exp  = {1'b0, sr_exp} + {1'b0, an_exp};
  // Max 63*63 + 48 = 4017, so 12 bits hold the rounded product without loss.
  assign wan_prod = ({6'd0, sr_mant} * {6'd0, an_mant}) + 12'd48;
  assign wan_mant = wan_prod[11:4];
  assign wan_base = {wan_mant, 7'd0};

  // Left shift for exponents above 26 deliberately wraps within 15 bits.
  always_comb begin
    if (wan_exp <= 5'd26) begin
      wan_mag = wan_base >> (5'd26 - wan_exp);
    end else begin
      wan_mag = wan_base << (wan_exp - 5'd26);
    end
  end

  assign WAnWBn = wan_s ? (16'd0 - {1'b0, wan_mag}) : {1'b0, wan_mag};

endmodule

// File: tb/tb_fmult.sv
// Directed self-checking bench for fmult using hand-computed G.726 FMULT products.
module tb_fmult;

  logic        clk;
  logic        reset;
  logic        scan_in0, scan_in1, scan_in2, scan_in3, scan_in4;
  logic        scan_enable;
  logic        test_mode;
  logic [15:0] AnBn;
  logic [10:0] SRnDQn;
  logic        scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;
  logic [15:0] WAnWBn;

  int errors = 0;
  int checks = 0;

  fmult dut (
    .clk        (clk),
    .reset      (reset),
    .scan_in0   (scan_in0),
    .scan_in1   (scan_in1),
    .scan_in2   (scan_in2),
    .scan_in3   (scan_in3),
    .scan_in4   (scan_in4),
    .scan_enable(scan_enable),
    .test_mode  (test_mode),
    .AnBn       (AnBn),
    .SRnDQn     (SRnDQn),
    .scan_out0  (scan_out0),
    .scan_out1  (scan_out1),
    .scan_out2  (scan_out2),
    .scan_out3  (scan_out3),
    .scan_out4  (scan_out4),
    .WAnWBn     (WAnWBn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic drive(input logic [15:0] a, input logic [10:0] s);
    @(negedge clk);
    AnBn   = a;
    SRnDQn = s;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    drive(16'h0000, 11'h000);
    checks++;
    if (WAnWBn !== 16'h0000) begin
      errors++;
      $display("FAIL reset_zero: got %h want 0000", WAnWBn);
    end
    checks++;
    if ({scan_out0, scan_out1, scan_out2, scan_out3, scan_out4} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_scan_out: got %b want 00000",
               {scan_out0, scan_out1, scan_out2, scan_out3, scan_out4});
    end
    reset = 1'b1;
  endtask

  task automatic test_basic;
    logic [15:0] a   [4] = '{16'h4000, 16'h2000, 16'h1234, 16'hFFFC};
    logic [10:0] s   [4] = '{11'h2A0, 11'h2A0, 11'h32D, 11'h3E0};
    logic [15:0] exp [4] = '{16'h0430, 16'h0218, 16'h0680, 16'hFFF8};
    for (int i = 0; i < 4; i++) begin
      drive(a[i], s[i]);
      checks++;
      if (WAnWBn !== exp[i]) begin
        errors++;
        $display("FAIL basic[%0d] a=%h s=%h: got %h want %h", i, a[i], s[i], WAnWBn, exp[i]);
      end
    end
  endtask

  task automatic test_sign;
    logic [15:0] a   [4] = '{16'hC000, 16'hC000, 16'hEDCC, 16'h8000};
    logic [10:0] s   [4] = '{11'h2A0, 11'h6A0, 11'h32D, 11'h3FF};
    logic [15:0] exp [4] = '{16'hFBD0, 16'h0430, 16'hF980, 16'hFFF8};
    for (int i = 0; i < 4; i++) begin
      drive(a[i], s[i]);
      checks++;
      if (WAnWBn !== exp[i]) begin
        errors++;
        $display("FAIL sign[%0d] a=%h s=%h: got %h want %h", i, a[i], s[i], WAnWBn, exp[i]);
      end
    end
  endtask

  task automatic test_exponent_edges;
    // Exponent sums 26, 27 and 28 (the last wraps past 15 bits).
    logic [15:0] a   [3] = '{16'h4000, 16'h4000, 16'h7FFC};
    logic [10:0] s   [3] = '{11'h360, 11'h3A0, 11'h3FF};
    logic [15:0] exp [3] = '{16'h2180, 16'h4300, 16'h7600};
    for (int i = 0; i < 3; i++) begin
      drive(a[i], s[i]);
      checks++;
      if (WAnWBn !== exp[i]) begin
        errors++;
        $display("FAIL exp_edge[%0d] a=%h s=%h: got %h want %h", i, a[i], s[i], WAnWBn, exp[i]);
      end
    end
  endtask

  task automatic test_zero_cases;
    logic [15:0] a   [3] = '{16'h0000, 16'h4000, 16'h0000};
    logic [10:0] s   [3] = '{11'h000, 11'h400, 11'h7FF};
    logic [15:0] exp [3] = '{16'h0000, 16'h0000, 16'hFFF8};
    for (int i = 0; i < 3; i++) begin
      drive(a[i], s[i]);
      checks++;
      if (WAnWBn !== exp[i]) begin
        errors++;
        $display("FAIL zero[%0d] a=%h s=%h: got %h want %h", i, a[i], s[i], WAnWBn, exp[i]);
      end
    end
  endtask

  task automatic test_dft_independence;
    drive(16'h1234, 11'h32D);
    @(negedge clk);
    reset       = 1'b0;
    scan_enable = 1'b1;
    test_mode   = 1'b1;
    {scan_in0, scan_in1, scan_in2, scan_in3, scan_in4} = 5'b10110;
    @(posedge clk);
    #1;
    checks++;
    if (WAnWBn !== 16'h0680) begin
      errors++;
      $display("FAIL dft_hold: got %h want 0680", WAnWBn);
    end
    checks++;
    if ({scan_out0, scan_out1, scan_out2, scan_out3, scan_out4} !== 5'b00000) begin
      errors++;
      $display("FAIL dft_scan_out: got %b want 00000",
               {scan_out0, scan_out1, scan_out2, scan_out3, scan_out4});
    end
    // Output must still track inputs while reset is held.
    drive(16'hC000, 11'h2A0);
    checks++;
    if (WAnWBn !== 16'hFBD0) begin
      errors++;
      $display("FAIL dft_track: got %h want FBD0", WAnWBn);
    end
    reset       = 1'b1;
    scan_enable = 1'b0;
    test_mode   = 1'b0;
    {scan_in0, scan_in1, scan_in2, scan_in3, scan_in4} = 5'b00000;
  endtask

  task automatic test_back_to_back;
    logic [15:0] a   [5] = '{16'h4000, 16'hC000, 16'h7FFC, 16'h1234, 16'h0000};
    logic [10:0] s   [5] = '{11'h2A0, 11'h2A0, 11'h3FF, 11'h32D, 11'h000};
    logic [15:0] exp [5] = '{16'h0430, 16'hFBD0, 16'h7600, 16'h0680, 16'h0000};
    for (int i = 0; i < 5; i++) begin
      drive(a[i], s[i]);
      checks++;
      if (WAnWBn !== exp[i]) begin
        errors++;
        $display("FAIL b2b[%0d] a=%h s=%h: got %h want %h", i, a[i], s[i], WAnWBn, exp[i]);
      end
    end
  endtask

  initial begin
    reset       = 1'b0;
    scan_enable = 1'b0;
    test_mode   = 1'b0;
    {scan_in0, scan_in1, scan_in2, scan_in3, scan_in4} = 5'b00000;
    AnBn   = 16'h0000;
    SRnDQn = 11'h000;
    test_reset();
    test_basic();
    test_sign();
    test_exponent_edges();
    test_zero_cases();
    test_dft_independence();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fmult.md
Name: fmult

Overview:
- Floating-point multiply stage of the G.726 ADPCM adaptive predictor.
- Converts a 16-bit two's-complement predictor coefficient (An or Bn) to floating point.
- Multiplies it by an 11-bit floating-point signal sample (SRn or DQn).
- Returns the 16-bit two's-complement partial product (WAn or WBn) to the accumulator.
- The same block serves all eight predictor taps (a1, a2, b1–b6), all rates (16/24/32/40 kbps) and both laws. Its datapath is purely combinational.

Parameters:
- None.

Ports:
- clk  input  1  system clock; no functional state in this block.
- reset  input  1  asynchronous, active-low reset; no functional effect (no state).
- scan_in0..scan_in4  input  1 each  scan chain inputs (DFT insertion).
- scan_enable  input  1  scan shift enable.
- test_mode  input  1  DFT test mode.
- AnBn  input  16  predictor coefficient, two's complement, Q14 (16384 = 1.0).
- SRnDQn  input  11  float operand: [10] sign, [9:6] exponent, [5:0] mantissa (normalised, MSB set unless zero).
- scan_out0..scan_out4  output  1 each  scan chain outputs; tied 0 in RTL.
- WAnWBn  output  16  product, two's complement.

Behaviour:
- Combinational data path. WAnWBn settles within the same clock period that AnBn/SRnDQn change; the consumer samples at the next rising clk.
- clk, reset, scan and test inputs do not alter WAnWBn.
- Coefficient to float conversion:
  - AnS = AnBn[15].
  - AnMAG (13 b) = AnBn[15:2] if AnS=0; otherwise (16384 − AnBn[15:2]) mod 8192, where AnBn[15:2] is taken as an unsigned logical shift.
  - AnEXP (4 b, 0..13) = bit position of the leading one of AnMAG, plus 1; 0 when AnMAG = 0.
  - AnMANT (6 b) = 32 when AnMAG = 0; otherwise (AnMAG << 6) >> AnEXP, so the MSB is set.
- Operand unpack: SRnS = SRnDQn[10], SRnEXP = SRnDQn[9:6], SRnMANT = SRnDQn[5:0].
- Product:
  - WAnS = SRnS XOR AnS.
  - WAnEXP (5 b) = SRnEXP + AnEXP, range 0..28.
  - WAnMANT (8 b) = (SRnMANT × AnMANT + 48) >> 4.
  - WAnMAG (15 b) = (WAnMANT << 7) >> (26 − WAnEXP) when WAnEXP ≤ 26.
  - WAnMAG (15 b) = ((WAnMANT << 7) << (WAnEXP − 26)) mod 32768 when WAnEXP > 26; the truncation to 15 bits is required and not saturated.
- Output: WAnWBn = WAnMAG if WAnS = 0; else (65536 − WAnMAG) mod 65536.
- Boundaries:
  - A zero magnitude with negative sign yields 0x0000.
  - AnBn = 0 still uses AnMANT = 32, so the +48 rounding term applies.
  - SRnDQn mantissa 0 gives WAnMANT = 3.
  - All intermediate widths are sized so no bits are lost before the final 15-bit mask.
- Reset mid-operation: output continues to follow the inputs.
- Must be bit-exact to the ITU-T G.726 FMULT reference for every input combination.

Test Plan:
- AnBn=0x0000, SRnDQn=0x000 -> WAnWBn=0x0000 (WAnMANT=3, WAnEXP=0, shifted out).
- AnBn=0x4000, SRnDQn=0x2A0 -> AnEXP=13, AnMANT=32, WAnMANT=67, WAnEXP=23 -> WAnWBn=0x0430.
- AnBn=0xC000, SRnDQn=0x2A0 -> negative coefficient -> WAnWBn=0xFBD0; same with SRnDQn=0x6A0 -> 0x0430 (double negation).
- AnBn=0x7FFC, SRnDQn=0x3FF -> WAnEXP=28, WAnMANT=251 -> overflow wrap -> WAnWBn=0x7600.
- AnBn=0x4000, SRnDQn=0x400 -> negative zero -> WAnWBn=0x0000.
- Stream G.726 reference vector files for a1/a2/b1–b6 at all rates, A/µ-law, encoder/decoder, reset/homing and normal/overload sequences. Apply one input pair per clock and check at the next rising edge -> zero mismatches.
